// File: rtl/iob_pcie_rx_ctrl.sv
// RIFFA-style PCIe RX channel sequencer: handshakes one CHNL_RX transaction and
// streams its 64-bit beats into the iob_pcie rxfifo write port, counting 32-bit words.
module iob_pcie_rx_ctrl #(
  parameter int DATA_W     = 32,
  parameter int PCI_DATA_W = 64,
  parameter int OFF_W      = 31
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  en_i,
  input  logic                  chnl_rx_i,
  input  logic                  chnl_rx_last_i,
  input  logic [DATA_W-1:0]     chnl_rx_len_i,
  input  logic [OFF_W-1:0]      chnl_rx_off_i,
  input  logic [PCI_DATA_W-1:0] chnl_rx_data_i,
  input  logic                  chnl_rx_data_valid_i,
  output logic                  chnl_rx_data_ren_o,
  output logic                  chnl_rx_ack_o,
  input  logic                  fifo_full_i,
  output logic                  fifo_wen_o,
  output logic [PCI_DATA_W-1:0] fifo_wdata_o,
  output logic [1:0]            fifo_wstrb_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  trunc_o,
  output logic [DATA_W-1:0]     rx_len_o,
  output logic [OFF_W-1:0]      rx_off_o,
  output logic                  rx_last_o,
  output logic [DATA_W-1:0]     rx_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    DATA,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   len_q, rem_q, cnt_q;
  logic [OFF_W-1:0]    off_q;
  logic                last_q, trunc_q, ack_q, done_q;

  logic                ren;
  logic                accept;
  logic [1:0]          strb;
  logic [DATA_W-1:0]   nwords;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ren     = 1'b0;
    accept  = 1'b0;
    strb    = 2'b00;
    nwords  = '0;
    unique case (state_q)
      IDLE: begin
        if (en_i && chnl_rx_i) state_d = ACK;
      end
      ACK: begin
        state_d = (len_q == '0) ? DONE : DATA;
      end
      DATA: begin
        ren    = ~fifo_full_i & (rem_q != '0);
        accept = ren & chnl_rx_data_valid_i;
        strb   = (rem_q >= DATA_W'(2)) ? 2'b11 : 2'b01;
        nwords = strb[1] ? DATA_W'(2) : DATA_W'(1);
        if (accept) begin
          if (rem_q == nwords) state_d = DONE;
        end else if (!chnl_rx_i) begin
          // Endpoint abandoned the transaction before the length was satisfied.
          state_d = DONE;
        end
      end
      DONE: begin
        // Wait for CHNL_RX to fall so the same transaction is not re-accepted.
        if (!chnl_rx_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all control and status registers are reset so that every output is 0 during reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      off_q   <= '0;
      last_q  <= 1'b0;
      rem_q   <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
      ack_q   <= (state_q == ACK);
      done_q  <= (state_d == DONE) && (state_q != DONE);
      if (state_q == IDLE && state_d == ACK) begin
        len_q   <= chnl_rx_len_i;
        off_q   <= chnl_rx_off_i;
        last_q  <= chnl_rx_last_i;
        rem_q   <= chnl_rx_len_i;
        cnt_q   <= '0;
        trunc_q <= 1'b0;
      end
      if (accept) begin
        rem_q <= rem_q - nwords;
        cnt_q <= cnt_q + nwords;
      end
      if (state_q == DATA && state_d == DONE && !accept) trunc_q <= 1'b1;
    end
  end

  assign chnl_rx_data_ren_o = ren;
  assign chnl_rx_ack_o      = ack_q;
  assign fifo_wen_o         = accept;
  assign fifo_wdata_o       = accept ? chnl_rx_data_i : '0;
  assign fifo_wstrb_o       = accept ? strb : 2'b00;
  assign busy_o             = (state_q != IDLE);
  assign done_o             = done_q;
  assign trunc_o            = trunc_q;
  assign rx_len_o           = len_q;
  assign rx_off_o           = off_q;
  assign rx_last_o          = last_q;
  assign rx_cnt_o           = cnt_q;

endmodule

// File: tb/tb_iob_pcie_rx_ctrl.sv
// Self-checking bench for iob_pcie_rx_ctrl: directed and randomized transactions
// compared against a word-level model of the expected FIFO write stream.
module tb_iob_pcie_rx_ctrl;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        en;
  logic        chnl_rx;
  logic        chnl_rx_last;
  logic [31:0] chnl_rx_len;
  logic [30:0] chnl_rx_off;
  logic [63:0] chnl_rx_data;
  logic        chnl_rx_data_valid;
  logic        ren;
  logic        ack;
  logic        fifo_full;
  logic        fifo_wen;
  logic [63:0] fifo_wdata;
  logic [1:0]  fifo_wstrb;
  logic        busy;
  logic        done;
  logic        trunc;
  logic [31:0] rx_len;
  logic [30:0] rx_off;
  logic        rx_last;
  logic [31:0] rx_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iob_pcie_rx_ctrl dut (
    .clk                  (clk),
    .arst_n               (arst_n),
    .en_i                 (en),
    .chnl_rx_i            (chnl_rx),
    .chnl_rx_last_i       (chnl_rx_last),
    .chnl_rx_len_i        (chnl_rx_len),
    .chnl_rx_off_i        (chnl_rx_off),
    .chnl_rx_data_i       (chnl_rx_data),
    .chnl_rx_data_valid_i (chnl_rx_data_valid),
    .chnl_rx_data_ren_o   (ren),
    .chnl_rx_ack_o        (ack),
    .fifo_full_i          (fifo_full),
    .fifo_wen_o           (fifo_wen),
    .fifo_wdata_o         (fifo_wdata),
    .fifo_wstrb_o         (fifo_wstrb),
    .busy_o               (busy),
    .done_o               (done),
    .trunc_o              (trunc),
    .rx_len_o             (rx_len),
    .rx_off_o             (rx_off),
    .rx_last_o            (rx_last),
    .rx_cnt_o             (rx_cnt)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] out_vec();
    logic [255:0] v;
    v = '0;
    v[167:0] = {ren, ack, fifo_wen, fifo_wdata, fifo_wstrb, busy, done, trunc,
                rx_len, rx_off, rx_last, rx_cnt};
    return v;
  endfunction

  // One transaction. The model: the first `words` 32-bit words of the stream
  // land in the FIFO two per beat, in order, with a single-word final beat when odd.
  task automatic run_txn(input string name, input int len, input logic [30:0] off,
                         input logic last, input int full_from, input int full_n,
                         input int drop_after, input bit rand_valid, input bit rand_full,
                         input bit en_drop);
    logic [63:0] src[$];
    logic [63:0] obs_d[$];
    logic [1:0]  obs_s[$];
    int words, exp_wr, idx, n, ack_n, ack_at, done_n, ren_full, hold;
    bit done_seen, dropped;
    words  = (drop_after >= 0 && 2 * drop_after < len) ? 2 * drop_after : len;
    exp_wr = (words + 1) / 2;
    idx = 0; n = 0; ack_n = 0; ack_at = -1; done_n = 0; ren_full = 0; hold = 0;
    done_seen = 0; dropped = 0;
    for (int i = 0; i < (len + 1) / 2 + 4; i++) src.push_back({$urandom, $urandom});

    @(posedge clk); #1;
    chnl_rx_len        = 32'(len);
    chnl_rx_off        = off;
    chnl_rx_last       = last;
    chnl_rx            = 1'b1;
    chnl_rx_data       = src[0];
    chnl_rx_data_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
    fifo_full          = 1'b0;

    while (hold < 5 && n < 400) begin
      @(negedge clk);
      if (ack) begin
        ack_n++;
        if (ack_at < 0) ack_at = n;
      end
      if (done) begin
        done_n++;
        done_seen = 1;
      end
      if (fifo_wen) begin
        obs_d.push_back(fifo_wdata);
        obs_s.push_back(fifo_wstrb);
      end
      if (ren && fifo_full) ren_full++;
      if (ren && chnl_rx_data_valid) idx++;
      @(posedge clk); #1;
      n++;
      if (en_drop && n == 3) en = 1'b0;
      if (done_seen) hold++;
      if (drop_after >= 0 && idx >= drop_after) dropped = 1;
      if (dropped || hold >= 3) begin
        chnl_rx            = 1'b0;
        chnl_rx_data_valid = 1'b0;
      end else begin
        chnl_rx_data_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      chnl_rx_data = src[idx];
      fifo_full = rand_full ? ($urandom_range(0, 2) == 0)
                            : (n >= full_from && n < full_from + full_n);
    end
    en        = 1'b1;
    fifo_full = 1'b0;

    check({name, "_finished"}, 256'(hold >= 5), 256'(1));
    check({name, "_ack_count"}, 256'(ack_n), 256'(1));
    check({name, "_ack_latency"}, 256'(ack_at), 256'(2));
    check({name, "_done_count"}, 256'(done_n), 256'(1));
    check({name, "_write_count"}, 256'(obs_d.size()), 256'(exp_wr));
    for (int i = 0; i < obs_d.size() && i < exp_wr; i++) begin
      check($sformatf("%s_wdata%0d", name, i), 256'(obs_d[i]), 256'(src[i]));
      check($sformatf("%s_wstrb%0d", name, i), 256'(obs_s[i]),
            256'((words - 2 * i >= 2) ? 2'b11 : 2'b01));
    end
    check({name, "_rx_cnt"}, 256'(rx_cnt), 256'(words));
    check({name, "_trunc"}, 256'(trunc), 256'(words < len));
    check({name, "_rx_len"}, 256'(rx_len), 256'(len));
    check({name, "_rx_off"}, 256'(rx_off), 256'(off));
    check({name, "_rx_last"}, 256'(rx_last), 256'(last));
    check({name, "_ren_while_full"}, 256'(ren_full), 256'(0));
    check({name, "_idle_after"}, 256'(busy), 256'(0));
  endtask

  initial begin
    int n;
    int ack_n, busy_n;
    bit seen;

    arst_n             = 1'b1;
    en                 = 1'b1;
    chnl_rx            = 1'b0;
    chnl_rx_last       = 1'b0;
    chnl_rx_len        = '0;
    chnl_rx_off        = '0;
    chnl_rx_data       = '0;
    chnl_rx_data_valid = 1'b0;
    fifo_full          = 1'b0;
    #2 arst_n = 1'b0;
    #1 check("reset_outputs", out_vec(), '0);
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
    check("post_reset_outputs", out_vec(), '0);

    run_txn("t1_len4", 4, 31'($urandom), 1'b0, 0, 0, -1, 1'b0, 1'b0, 1'b0);
    run_txn("t2_len5", 5, 31'($urandom), 1'b1, 0, 0, -1, 1'b0, 1'b0, 1'b1);
    run_txn("t3_full", 8, 31'($urandom), 1'b0, 4, 3, -1, 1'b0, 1'b0, 1'b0);
    run_txn("t4_drop", 8, 31'($urandom), 1'b1, 0, 0, 2, 1'b0, 1'b0, 1'b0);
    run_txn("t5_len0", 0, 31'($urandom), 1'b1, 0, 0, -1, 1'b0, 1'b0, 1'b0);

    // Disabled controller must ignore a pending transaction.
    @(posedge clk); #1;
    en          = 1'b0;
    chnl_rx     = 1'b1;
    chnl_rx_len = 32'd4;
    ack_n = 0; busy_n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack) ack_n++;
      if (busy) busy_n++;
    end
    check("en0_ack_count", 256'(ack_n), 256'(0));
    check("en0_busy_count", 256'(busy_n), 256'(0));
    @(posedge clk); #1;
    chnl_rx = 1'b0;
    en      = 1'b1;

    // Asynchronous reset in the middle of the data phase.
    @(posedge clk); #1;
    chnl_rx_len        = 32'd8;
    chnl_rx_off        = 31'd5;
    chnl_rx_last       = 1'b1;
    chnl_rx            = 1'b1;
    chnl_rx_data_valid = 1'b1;
    chnl_rx_data       = {$urandom, $urandom};
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (fifo_wen) seen = 1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("t6_reached_data", 256'(seen), 256'(1));
    #1 arst_n = 1'b0;
    #1 check("t6_reset_mid_data", out_vec(), '0);
    chnl_rx            = 1'b0;
    chnl_rx_data_valid = 1'b0;
    @(posedge clk); #1;
    check("t6_reset_held", out_vec(), '0);
    arst_n = 1'b1;
    run_txn("t6_len2", 2, 31'($urandom), 1'b0, 0, 0, -1, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 4; t++) begin
      run_txn($sformatf("rand%0d", t), int'($urandom_range(1, 15)), 31'($urandom),
              1'($urandom), 0, 0, -1, 1'b1, 1'b1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
